// File: rtl/alu_pkg.sv
// Shared opcodes, instruction layout, FSM states and helpers for the ALU issue controller.
package alu_pkg;

    localparam int unsigned WIDTH        = 16;
    localparam int unsigned NREGS        = 8;
    localparam int unsigned RIDX_W       = 3;
    localparam int unsigned OP_W         = 5;
    localparam int unsigned IMM_W        = 8;
    localparam int unsigned OP_USE_CARRY = 4;

    typedef enum logic [3:0] {
        OP_B       = 4'd0,
        OP_ADD     = 4'd1,
        OP_SUB     = 4'd2,
        OP_AND     = 4'd3,
        OP_OR      = 4'd4,
        OP_XOR     = 4'd5,
        OP_NOT     = 4'd6,
        OP_NEG     = 4'd7,
        OP_LSL     = 4'd8,
        OP_LSR     = 4'd9,
        OP_ASR     = 4'd10,
        OP_INC     = 4'd11,
        OP_DEC     = 4'd12,
        OP_MUL     = 4'd13,
        OP_LDI     = 4'd14,
        OP_ILLEGAL = 4'd15
    } opcode_e;

    // Field order matches instr[15:0]; imm8 overlays ra/rb/rsvd for LDI.
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [RIDX_W-1:0] rd;
        logic [RIDX_W-1:0] ra;
        logic [RIDX_W-1:0] rb;
        logic [1:0]        rsvd;
    } instr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_e;

    function automatic logic [IMM_W-1:0] imm8_of(input instr_t i);
        return {i.ra, i.rb, i.rsvd};
    endfunction

    function automatic logic updates_carry(input opcode_e op);
        return op inside {OP_ADD, OP_SUB, OP_LSL, OP_LSR};
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// 8x16 register file: two combinational operand reads, a debug read and one synchronous write.
module alu_regfile
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [RIDX_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [RIDX_W-1:0] raddr_a_i,
    input  logic [RIDX_W-1:0] raddr_b_i,
    input  logic [RIDX_W-1:0] dbg_addr_i,
    output logic [WIDTH-1:0]  rdata_a_c_o,
    output logic [WIDTH-1:0]  rdata_b_c_o,
    output logic [WIDTH-1:0]  dbg_data_c_o
);

    logic [WIDTH-1:0] regs_q [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_c_o  = regs_q[raddr_a_i];
    assign rdata_b_c_o  = regs_q[raddr_b_i];
    assign dbg_data_c_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller driving an external 16-bit ALU from an internal register file.
module alu_issue_ctrl
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              nReset,
    input  logic              instrValid,
    output logic              instrReady,
    input  logic [WIDTH-1:0]  instr,
    output logic [WIDTH-1:0]  aluA,
    output logic [WIDTH-1:0]  aluB,
    output logic [OP_W-1:0]   aluOp,
    output logic              aluCi,
    input  logic [WIDTH-1:0]  aluY,
    input  logic              aluZero,
    input  logic              aluNeg,
    input  logic              aluCarry,
    output logic              doneValid,
    output logic              doneErr,
    output logic              flagZ,
    output logic              flagN,
    output logic              flagC,
    input  logic [RIDX_W-1:0] dbgSel,
    output logic [WIDTH-1:0]  dbgData
);

    state_e           state_q, state_d;
    instr_t           instr_q, instr_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, y_q, y_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic             z_q, z_d, n_q, n_d, c_q, c_d;
    logic             fz_q, fz_d, fn_q, fn_d, fc_q, fc_d;
    logic             ready_q, ready_d, done_q, done_d, err_q, err_d;

    logic             we_c;
    logic [WIDTH-1:0] wdata_c, rdata_a_c, rdata_b_c;
    opcode_e          op_base_c;

    assign op_base_c = opcode_e'(instr_q.op[3:0]);

    alu_regfile u_regfile (
        .clk          (clk),
        .rst_n        (nReset),
        .we_i         (we_c),
        .waddr_i      (instr_q.rd),
        .wdata_i      (wdata_c),
        .raddr_a_i    (instr_q.ra),
        .raddr_b_i    (instr_q.rb),
        .dbg_addr_i   (dbgSel),
        .rdata_a_c_o  (rdata_a_c),
        .rdata_b_c_o  (rdata_b_c),
        .dbg_data_c_o (dbgData)
    );

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
            instr_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            y_q     <= '0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            c_q     <= 1'b0;
            fz_q    <= 1'b0;
            fn_q    <= 1'b0;
            fc_q    <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            y_q     <= y_d;
            z_q     <= z_d;
            n_q     <= n_d;
            c_q     <= c_d;
            fz_q    <= fz_d;
            fn_q    <= fn_d;
            fc_q    <= fc_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state, datapath capture and writeback control.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        y_d     = y_q;
        z_d     = z_q;
        n_d     = n_q;
        c_d     = c_q;
        fz_d    = fz_q;
        fn_d    = fn_q;
        fc_d    = fc_q;
        we_c    = 1'b0;
        wdata_c = y_q;

        case (state_q)
            IDLE: begin
                if (instrValid && ready_q) begin
                    instr_d = instr_t'(instr);
                    state_d = READ;
                end
            end
            READ: begin
                a_d  = rdata_a_c;
                b_d  = rdata_b_c;
                op_d = instr_q.op;
                if (op_base_c == OP_LDI || op_base_c == OP_ILLEGAL) begin
                    state_d = WB;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                y_d     = aluY;
                z_d     = aluZero;
                n_d     = aluNeg;
                c_d     = aluCarry;
                state_d = WB;
            end
            WB: begin
                state_d = IDLE;
                if (op_base_c == OP_LDI) begin
                    we_c    = 1'b1;
                    wdata_c = WIDTH'(imm8_of(instr_q));
                end else if (op_base_c != OP_ILLEGAL) begin
                    we_c = 1'b1;
                    fz_d = z_q;
                    fn_d = n_q;
                    if (updates_carry(op_base_c)) begin
                        fc_d = c_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
        done_d  = (state_d == WB);
        err_d   = (state_d == WB) && (op_base_c == OP_ILLEGAL);
    end

    assign instrReady = ready_q;
    assign aluA       = a_q;
    assign aluB       = b_q;
    assign aluOp      = op_q;
    assign aluCi      = fc_q;
    assign doneValid  = done_q;
    assign doneErr    = err_q;
    assign flagZ      = fz_q;
    assign flagN      = fn_q;
    assign flagC      = fc_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench: behavioural ALU beside the controller, reference register/flag model, done monitor.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        nReset;
    logic        instrValid;
    logic        instrReady;
    logic [15:0] instr;
    logic [15:0] aluA, aluB, aluY;
    logic [4:0]  aluOp;
    logic        aluCi, aluZero, aluNeg, aluCarry;
    logic        doneValid, doneErr, flagZ, flagN, flagC;
    logic [2:0]  dbgSel;
    logic [15:0] dbgData;

    logic        force_en, force_val;
    int unsigned cyc;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic        err;
        logic [2:0]  rd;
        logic [15:0] val;
        logic        fz, fn, fc;
        int unsigned hs;
        int unsigned lat;
    } exp_t;
    exp_t sb[$];

    logic [15:0] m_regs [8];
    logic        m_fz, m_fn, m_fc;

    alu_issue_ctrl dut (
        .clk        (clk),
        .nReset     (nReset),
        .instrValid (instrValid),
        .instrReady (instrReady),
        .instr      (instr),
        .aluA       (aluA),
        .aluB       (aluB),
        .aluOp      (aluOp),
        .aluCi      (aluCi),
        .aluY       (aluY),
        .aluZero    (aluZero),
        .aluNeg     (aluNeg),
        .aluCarry   (aluCarry),
        .doneValid  (doneValid),
        .doneErr    (doneErr),
        .flagZ      (flagZ),
        .flagN      (flagN),
        .flagC      (flagC),
        .dbgSel     (dbgSel),
        .dbgData    (dbgData)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Returns {carry, result}; carry-in only counts when op[4] is set.
    function automatic logic [16:0] alu_fn(input logic [4:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic ci);
        logic        cin;
        logic [15:0] prod;
        cin  = op[4] & ci;
        prod = a * b;
        case (op[3:0])
            4'd0:    return {1'b0, b};
            4'd1:    return {1'b0, a} + {1'b0, b} + {16'd0, cin};
            4'd2:    return {1'b0, a} - {1'b0, b} - {16'd0, cin};
            4'd3:    return {1'b0, a & b};
            4'd4:    return {1'b0, a | b};
            4'd5:    return {1'b0, a ^ b};
            4'd6:    return {1'b0, ~a};
            4'd7:    return {1'b0, 16'd0 - a};
            4'd8:    return {a[15], a[14:0], 1'b0};
            4'd9:    return {a[0], 1'b0, a[15:1]};
            4'd10:   return {a[0], a[15], a[15:1]};
            4'd11:   return {1'b0, a + 16'd1};
            4'd12:   return {1'b0, a - 16'd1};
            default: return {1'b0, prod};
        endcase
    endfunction

    always_comb begin
        logic [16:0] r;
        r        = alu_fn(aluOp, aluA, aluB, aluCi);
        aluY     = r[15:0];
        aluZero  = (r[15:0] == 16'd0);
        aluNeg   = r[15];
        aluCarry = force_en ? force_val : r[16];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mk(input int op, input int rd, input int ra, input int rb);
        return {5'(op), 3'(rd), 3'(ra), 3'(rb), 2'b00};
    endfunction

    function automatic logic [15:0] mk_ldi(input int rd, input logic [7:0] imm);
        return {5'd14, 3'(rd), imm};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 16'd0;
        m_fz = 1'b0;
        m_fn = 1'b0;
        m_fc = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!instrReady && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", 32'(instrReady), 32'd1);
    endtask

    // Issue one instruction, update the reference model, and spot-check the busy window.
    task automatic issue(input logic [15:0] ins, input bit fen, input bit fval, input bit junk);
        logic [3:0]  o;
        logic [2:0]  rd, ra, rb;
        logic [15:0] va, vb;
        logic        fc_before;
        logic [16:0] r;
        exp_t        e;
        o  = ins[14:11];
        rd = ins[10:8];
        ra = ins[7:5];
        rb = ins[4:2];
        wait_ready();
        force_en   = fen;
        force_val  = fval;
        instr      = ins;
        instrValid = 1'b1;
        @(posedge clk);
        #1;
        instrValid = junk;
        instr      = 16'($urandom);
        dbgSel     = rd;

        va        = m_regs[ra];
        vb        = m_regs[rb];
        fc_before = m_fc;
        e.err     = 1'b0;
        e.rd      = rd;
        e.hs      = cyc;
        if (o == 4'd15) begin
            e.err = 1'b1;
            e.lat = 2;
        end else if (o == 4'd14) begin
            m_regs[rd] = {8'h00, ins[7:0]};
            e.lat      = 2;
        end else begin
            r          = alu_fn(ins[15:11], va, vb, m_fc);
            m_regs[rd] = r[15:0];
            m_fz       = (r[15:0] == 16'd0);
            m_fn       = r[15];
            if (o inside {4'd1, 4'd2, 4'd8, 4'd9}) m_fc = fen ? fval : r[16];
            e.lat      = 3;
        end
        e.val = m_regs[rd];
        e.fz  = m_fz;
        e.fn  = m_fn;
        e.fc  = m_fc;
        sb.push_back(e);

        @(negedge clk);
        chk("ready_low_read", 32'(instrReady), 32'd0);
        if (o < 4'd14) begin
            @(negedge clk);
            chk("ready_low_exec", 32'(instrReady), 32'd0);
            chk("exec_aluA", 32'(aluA), 32'(va));
            chk("exec_aluB", 32'(aluB), 32'(vb));
            chk("exec_aluOp", 32'(aluOp), 32'(ins[15:11]));
            chk("exec_aluCi", 32'(aluCi), 32'(fc_before));
        end
        @(negedge clk);
        instrValid = 1'b0;
        chk("ready_low_wb", 32'(instrReady), 32'd0);
    endtask

    // Monitor: pop on each retirement, then check writeback visible the following cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (nReset && doneValid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'(doneValid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("done_err", 32'(doneErr), 32'(e.err));
                    chk("done_latency", cyc - e.hs + 1, e.lat);
                    @(negedge clk);
                    chk("done_single_pulse", 32'(doneValid), 32'd0);
                    chk("wb_reg", 32'(dbgData), 32'(e.val));
                    chk("wb_flagZ", 32'(flagZ), 32'(e.fz));
                    chk("wb_flagN", 32'(flagN), 32'(e.fn));
                    chk("wb_flagC", 32'(flagC), 32'(e.fc));
                    chk("aluCi_eq_flagC", 32'(aluCi), 32'(e.fc));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc        = 0;
        nReset     = 1'b0;
        instrValid = 1'b0;
        instr      = 16'd0;
        dbgSel     = 3'd0;
        force_en   = 1'b0;
        force_val  = 1'b0;
        model_reset();
        #12;
        chk("rst_ready", 32'(instrReady), 32'd1);
        chk("rst_done", 32'(doneValid), 32'd0);
        chk("rst_aluOp", 32'(aluOp), 32'd0);
        chk("rst_flags", 32'({flagZ, flagN, flagC}), 32'd0);
        #10;
        nReset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            dbgSel = 3'(i);
            #1;
            chk("rst_reg", 32'(dbgData), 32'd0);
        end

        issue(mk_ldi(1, 8'h34), 1'b0, 1'b0, 1'b0);
        issue(mk_ldi(2, 8'h12), 1'b0, 1'b0, 1'b1);
        issue(mk(1, 3, 1, 2), 1'b0, 1'b0, 1'b1);
        issue(mk(2, 4, 2, 2), 1'b0, 1'b0, 1'b0);
        issue(mk(6, 5, 4, 0), 1'b0, 1'b0, 1'b0);
        issue(mk(8, 0, 1, 0), 1'b1, 1'b1, 1'b0);
        issue(mk(17, 6, 1, 2), 1'b0, 1'b0, 1'b0);
        issue(mk(3, 2, 1, 2), 1'b1, 1'b0, 1'b0);
        issue(mk(15, 3, 1, 2), 1'b0, 1'b0, 1'b1);
        issue(mk(1, 3, 3, 3), 1'b0, 1'b0, 1'b0);
        wait_ready();
        chk("r3_direct", 32'(m_regs[3]), 32'h008c);

        // Reset during EXEC of ADD r7 aborts without writeback.
        instr      = mk(1, 7, 1, 2);
        instrValid = 1'b1;
        @(posedge clk);
        #1;
        instrValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        nReset = 1'b0;
        sb.delete();
        model_reset();
        #1;
        chk("midrst_ready", 32'(instrReady), 32'd1);
        chk("midrst_done", 32'(doneValid), 32'd0);
        @(negedge clk);
        nReset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            dbgSel = 3'(i);
            #1;
            chk("midrst_reg", 32'(dbgData), 32'(m_regs[i]));
        end
        chk("midrst_flags", 32'({flagZ, flagN, flagC}), 32'd0);
        repeat (4) @(negedge clk);

        for (int i = 0; i < 8; i++) issue(mk_ldi(i, 8'($urandom)), 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 60; n++) begin
            logic [15:0] ins;
            ins = 16'($urandom);
            if ($urandom_range(0, 9) == 0) ins[14:11] = 4'd15;
            issue(ins, 1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
